// File: rtl/act_video_scaler.sv
// act_video_scaler: VGA timing generator that fetches a CH-channel activation
// map from a 1-cycle synchronous-read memory and upscales it by 2^SCALE_LOG2
// using nearest-neighbour replication. All pin outputs are registered and
// share one latency of LAT = 2^SCALE_LOG2 + 1 cycles from the internal counters.
// Optional build macro ACT_GRID_EN draws a white grid on in-image tile edges.
module act_video_scaler #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_NEG   = 1,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int SCALE_LOG2 = 3,
    parameter int CH         = 3,
    parameter int DW         = 8,
    parameter int OUT_W      = 4,
    parameter int BIT_OFF    = 1,
    parameter int ADDR_W     = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DW-1:0]      mem_rd_data,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [3*OUT_W-1:0] rgb,
    output logic               frame_start
);

    localparam int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   TILE      = 1 << SCALE_LOG2;
    localparam int   LAT       = TILE + 1;
    localparam int   HW        = $clog2(H_TOTAL);
    localparam int   VW        = $clog2(V_TOTAL);
    localparam int   CW        = (CH > 1) ? $clog2(CH) : 1;
    localparam int   G_IDX     = (CH > 1) ? 1 : 0;
    localparam int   B_IDX     = (CH > 2) ? 2 : 0;
    localparam logic SYNC_IDLE = (SYNC_NEG != 0);

    // A read issued at a tile start lands in shadow two cycles after it leaves
    // the pins, so the last channel must be captured before the next tile start.
    if (CH != 1 && CH != 3) begin : g_ch_chk
        $error("act_video_scaler: CH must be 1 or 3");
    end
    if (SCALE_LOG2 < 1 || CH + 2 > TILE) begin : g_tile_chk
        $error("act_video_scaler: tile too small for CH reads");
    end

    typedef enum logic {IDLE, FETCH} state_t;

    logic [HW-1:0]     h;
    logic [VW-1:0]     v;
    int                hi, vi, tx_i, ty_i, base_i;
    logic              raw_de, raw_hs, raw_vs, raw_fs, tile_start, in_img;
    logic [ADDR_W-1:0] base_now;

    state_t            state, state_nx;
    logic [CW-1:0]     c_q, c_nx, rd_idx, idx_nx, cap_idx;
    logic [ADDR_W-1:0] base_q, base_nx, addr_nx;
    logic              rd_en_nx, cap_vld;

    logic [DW-1:0]     shadow  [CH];
    logic [DW-1:0]     display [CH];
    logic [DW-1:0]     disp_nx [CH];
    logic [3*OUT_W-1:0] col;

    logic [LAT-1:0]    de_p, hs_p, vs_p, fs_p;
`ifdef ACT_GRID_EN
    logic [LAT-1:0]    grid_p;
    logic              raw_grid;
`endif

    function automatic logic [OUT_W-1:0] chan(input logic [DW-1:0] a);
        return a[BIT_OFF +: OUT_W];
    endfunction

    assign hi         = int'(h);
    assign vi         = int'(v);
    assign tx_i       = hi >> SCALE_LOG2;
    assign ty_i       = vi >> SCALE_LOG2;
    assign raw_de     = (hi < H_ACTIVE) && (vi < V_ACTIVE);
    assign raw_hs     = ((hi >= H_ACTIVE + H_FP) && (hi < H_ACTIVE + H_FP + H_SYNC)) ^ SYNC_IDLE;
    assign raw_vs     = ((vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC)) ^ SYNC_IDLE;
    assign raw_fs     = (hi == 0) && (vi == 0);
    assign tile_start = (hi & (TILE - 1)) == 0;
    assign in_img     = raw_de && (tx_i < IMG_W) && (ty_i < IMG_H);
    assign base_i     = (ty_i * IMG_W + tx_i) * CH;
    assign base_now   = ADDR_W'(base_i);
`ifdef ACT_GRID_EN
    assign raw_grid   = in_img && (tile_start || ((vi & (TILE - 1)) == 0));
`endif

    // Raster counters: h wraps at H_TOTAL, v advances on each h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (hi == H_TOTAL - 1) begin
            h <= '0;
            v <= (vi == V_TOTAL - 1) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Fetch FSM state and registered memory request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            c_q       <= '0;
            base_q    <= '0;
            rd_idx    <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
        end else begin
            state     <= state_nx;
            c_q       <= c_nx;
            base_q    <= base_nx;
            rd_idx    <= idx_nx;
            mem_rd_en <= rd_en_nx;
            mem_addr  <= addr_nx;
            cap_vld   <= mem_rd_en;
            cap_idx   <= rd_idx;
        end
    end

    // Fetch FSM next state: channel 0 at the tile start, the rest on following cycles.
    always_comb begin
        state_nx = state;
        c_nx     = c_q;
        base_nx  = base_q;
        idx_nx   = rd_idx;
        rd_en_nx = 1'b0;
        addr_nx  = mem_addr;
        case (state)
            IDLE: begin
                if (tile_start && in_img) begin
                    rd_en_nx = 1'b1;
                    addr_nx  = base_now;
                    base_nx  = base_now;
                    idx_nx   = '0;
                    c_nx     = CW'(1);
                    if (CH > 1) state_nx = FETCH;
                end
            end
            FETCH: begin
                rd_en_nx = 1'b1;
                addr_nx  = base_q + ADDR_W'(c_q);
                idx_nx   = c_q;
                c_nx     = c_q + CW'(1);
                if (int'(c_q) == CH - 1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Shadow capture of returned words; cleared at out-of-image tile starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) shadow[c] <= '0;
        end else if (tile_start && !in_img) begin
            for (int c = 0; c < CH; c++) shadow[c] <= '0;
        end else if (cap_vld) begin
            shadow[cap_idx] <= mem_rd_data;
        end
    end

    // Display regs take the completed shadow at every tile start.
    always_ff @(posedge clk) begin
        if (tile_start) begin
            for (int c = 0; c < CH; c++) display[c] <= shadow[c];
        end
    end

    // Colour of the tile being shown next cycle (shadow bypass at tile start).
    always_comb begin
        for (int c = 0; c < CH; c++) disp_nx[c] = tile_start ? shadow[c] : display[c];
        col = {chan(disp_nx[0]), chan(disp_nx[G_IDX]), chan(disp_nx[B_IDX])};
    end

    // Timing pipeline: stage 0 takes the raw counter decode, stage LAT-1 drives the pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_p   <= '0;
            hs_p   <= {LAT{SYNC_IDLE}};
            vs_p   <= {LAT{SYNC_IDLE}};
            fs_p   <= '0;
`ifdef ACT_GRID_EN
            grid_p <= '0;
`endif
        end else begin
            de_p   <= {de_p[LAT-2:0], raw_de};
            hs_p   <= {hs_p[LAT-2:0], raw_hs};
            vs_p   <= {vs_p[LAT-2:0], raw_vs};
            fs_p   <= {fs_p[LAT-2:0], raw_fs};
`ifdef ACT_GRID_EN
            grid_p <= {grid_p[LAT-2:0], raw_grid};
`endif
        end
    end

    // Output colour register, aligned with the final timing stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= '0;
        end else if (!de_p[LAT-2]) begin
            rgb <= '0;
`ifdef ACT_GRID_EN
        end else if (grid_p[LAT-2]) begin
            rgb <= '1;
`endif
        end else begin
            rgb <= col;
        end
    end

    assign de          = de_p[LAT-1];
    assign h_sync      = hs_p[LAT-1];
    assign v_sync      = vs_p[LAT-1];
    assign frame_start = fs_p[LAT-1];

endmodule

// File: tb/tb_act_video_scaler.sv
// Directed bench for act_video_scaler: a default CH=3 instance and a CH=1
// instance with a short frame (30 lines, 2 tile rows) sharing clock and reset.
`timescale 1ns/1ps
module tb_act_video_scaler;

`ifdef ACT_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rd_en0, hs0, vs0, de0, fs0;
    logic [13:0] addr0;
    logic [7:0]  rdata0 = '0;
    logic [11:0] rgb0;

    logic        rd_en1, hs1, vs1, de1, fs1;
    logic [13:0] addr1;
    logic [7:0]  rdata1 = '0;
    logic [11:0] rgb1;

    int t = 0, checks = 0, errs = 0;
    int rd0 = 0, rd1 = 0, bad0 = 0, bad1 = 0, de_cnt = 0, hs_lo = 0, fs_cnt = 0;

    always #5 clk = ~clk;

    act_video_scaler dut (
        .clk(clk), .rst_n(rst_n), .mem_rd_en(rd_en0), .mem_addr(addr0),
        .mem_rd_data(rdata0), .h_sync(hs0), .v_sync(vs0), .de(de0),
        .rgb(rgb0), .frame_start(fs0)
    );

    act_video_scaler #(.CH(1), .IMG_H(2), .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_rd_en(rd_en1), .mem_addr(addr1),
        .mem_rd_data(rdata1), .h_sync(hs1), .v_sync(vs1), .de(de1),
        .rgb(rgb1), .frame_start(fs1)
    );

    // 1-cycle synchronous-read memories
    always @(posedge clk) if (rd_en0) rdata0 <= addr0[7:0];
    always @(posedge clk) if (rd_en1) rdata1 <= (addr1 == 14'd65) ? 8'h1E : addr1[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // A read on the pins at counter cycle tt must belong to an in-image tile
    // start k=1..ch cycles earlier and carry that tile's channel address.
    function automatic bit rd_ok(input int tt, input logic [13:0] a, input int ch,
                                 input int rows, input int vtot, input int vact);
        int h  = tt % 800;
        int v  = (tt / 800) % vtot;
        int k  = h % 8;
        int tx = (h - k) / 8;
        if (k < 1 || k > ch) return 1'b0;
        if (tx >= 64 || (v / 8) >= rows || v >= vact) return 1'b0;
        return int'(a) == (((v / 8) * 64 + tx) * ch + k - 1);
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            t++;
            if (de0) de_cnt++;
            if (!hs0) hs_lo++;
            if (fs0) fs_cnt++;
            if (rd_en0) begin
                rd0++;
                if (!rd_ok(t, addr0, 3, 64, 525, 480)) bad0++;
            end
            if (rd_en1) begin
                rd1++;
                if (!rd_ok(t, addr1, 1, 2, 30, 24)) bad1++;
            end
        end
    endtask

    task automatic goto(input int tt);
        step(tt - t);
    endtask

    initial begin
        // reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de", 32'(de0), 32'd0);
        chk("rst_rgb", 32'(rgb0), 32'd0);
        chk("rst_hs", 32'(hs0), 32'd1);
        chk("rst_vs", 32'(vs0), 32'd1);
        chk("rst_fs", 32'(fs0), 32'd0);
        chk("rst_rd", 32'(rd_en0), 32'd0);
        chk("rst_addr", 32'(addr0), 32'd0);
        chk("rst_hs1", 32'(hs1), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;

        // frame_start latency
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("fs_early", 32'(fs0), 32'd0);
        end
        de_cnt = 0; hs_lo = 0; fs_cnt = 0;
        step(1);
        chk("fs_lat", 32'(fs0), 32'd1);
        chk("fs_lat1", 32'(fs1), 32'd1);
        chk("px0_de", 32'(de0), 32'd1);
        chk("px0_rgb", 32'(rgb0), GRID ? 32'hFFF : 32'h001);
        step(1);
        chk("fs_pulse", 32'(fs0), 32'd0);

        // line 0 totals
        goto(808);
        chk("de_cnt", 32'(de_cnt), 32'd640);
        chk("hs_lo", 32'(hs_lo), 32'd96);
        chk("fs_cnt", 32'(fs_cnt), 32'd1);

        // line 1 edges
        goto(1448); chk("de_last", 32'(de0), 32'd1);
        goto(1449); chk("de_off", 32'(de0), 32'd0);
        goto(1464); chk("hs_pre", 32'(hs0), 32'd1);
        goto(1465); chk("hs_on", 32'(hs0), 32'd0);
        goto(1560); chk("hs_end", 32'(hs0), 32'd0);
        goto(1561); chk("hs_off", 32'(hs0), 32'd1);

        // reads of lines 0..7 and tile (2,1)
        goto(6400); chk("rd0_cnt", 32'(rd0), 32'd1536);
        goto(6417); chk("rd_a0_en", 32'(rd_en0), 32'd1); chk("rd_a0", 32'(addr0), 32'd198);
        goto(6418); chk("rd_a1", 32'(addr0), 32'd199);
        goto(6419); chk("rd_a2", 32'(addr0), 32'd200);
        goto(6420); chk("rd_done", 32'(rd_en0), 32'd0);

        // colours on lines 8 and 9
        goto(6425); chk("px16_8", 32'(rgb0), GRID ? 32'hFFF : 32'h334); chk("px16_8_de", 32'(de0), 32'd1);
        goto(6432); chk("px23_8", 32'(rgb0), GRID ? 32'hFFF : 32'h334);
        goto(6433); chk("px24_8", 32'(rgb0), GRID ? 32'hFFF : 32'h455);
        goto(6921); chk("px512_rgb", 32'(rgb0), 32'd0); chk("px512_de", 32'(de0), 32'd1);
        goto(7048); chk("px639_rgb", 32'(rgb0), 32'd0); chk("px639_de", 32'(de0), 32'd1);
        goto(7049); chk("px640_de", 32'(de0), 32'd0);
        goto(7217); chk("px8_9", 32'(rgb0), GRID ? 32'hFFF : 32'h122);
        goto(7218); chk("px9_9", 32'(rgb0), 32'h122);
        goto(7226); chk("px17_9", 32'(rgb0), 32'h334);
        goto(7720); chk("px511_9", 32'(rgb0), 32'hEFF);
        goto(7721); chk("px512_9", 32'(rgb0), 32'd0);

        // CH=1 instance
        goto(9621);  chk("g_px12_12", 32'(rgb1), 32'hFFF);
        goto(9626);  chk("g_px17_12", 32'(rgb1), 32'h111);
        goto(12821); chk("g_row2_rgb", 32'(rgb1), 32'd0); chk("g_row2_de", 32'(de1), 32'd1);
        goto(19221); chk("g_blank_de", 32'(de1), 32'd0);
        goto(20808); chk("g_vs_pre", 32'(vs1), 32'd1);
        goto(20809); chk("g_vs_on", 32'(vs1), 32'd0);
        goto(22408); chk("g_vs_end", 32'(vs1), 32'd0);
        goto(22409); chk("g_vs_off", 32'(vs1), 32'd1);
        goto(24000); chk("g_rd_cnt", 32'(rd1), 32'd1024);
        goto(24008); chk("g_fs_pre", 32'(fs1), 32'd0);
        goto(24009); chk("g_fs_per", 32'(fs1), 32'd1);

        // reset in the middle of a fetch
        goto(24417);
        chk("mid_rd", 32'(rd_en0), 32'd1);
        chk("mid_addr", 32'(addr0), 32'd732);
        chk("mid_rd1", 32'(rd_en1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd", 32'(rd_en0), 32'd0);
        chk("arst_addr", 32'(addr0), 32'd0);
        chk("arst_de", 32'(de0), 32'd0);
        chk("arst_rd1", 32'(rd_en1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        step(1); chk("rel_rd", 32'(rd_en0), 32'd1); chk("rel_a0", 32'(addr0), 32'd0);
        step(1); chk("rel_a1", 32'(addr0), 32'd1);
        step(1); chk("rel_a2", 32'(addr0), 32'd2);
        for (int k = 4; k <= 9; k++) begin
            step(1);
            chk("rel_fs", 32'(fs0), 32'(k == 9));
        end

        chk("bad_rd0", 32'(bad0), 32'd0);
        chk("bad_rd1", 32'(bad1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
